// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-port memory arbiter: state encoding,
// requester indices and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] REQ_FETCH = 2'd0;
  localparam logic [IDX_W-1:0] REQ_DATA  = 2'd1;
  localparam logic [IDX_W-1:0] REQ_DEBUG = 2'd2;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  // Round-robin successor, wrapping the debug port back to fetch.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i >= REQ_DEBUG) ? REQ_FETCH : i + REQ_DATA;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from the debug port back to instruction fetch.
module rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] c0;
  logic [IDX_W-1:0] c1;
  logic [IDX_W-1:0] c2;

  // An out-of-range pointer is treated as pointing at fetch.
  assign c0 = (ptr > REQ_DEBUG) ? REQ_FETCH : ptr;
  assign c1 = next_idx(c0);
  assign c2 = next_idx(c1);

  always_comb begin
    winner = REQ_FETCH;
    valid  = 1'b1;
    if (req[c0]) begin
      winner = c0;
    end else if (req[c1]) begin
      winner = c1;
    end else if (req[c2]) begin
      winner = c2;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter: round-robin grant, one transaction in
// flight, bounded wait on mem_ready with a timeout error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [IDX_W-1:0]   win_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               timeout_hit;

  rr_arbiter u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (win_idx),
    .valid  (win_vld)
  );

  // This is the last allowed ACCESS cycle; a coincident mem_ready still wins.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1)) && !mem_ready;
  assign rdata       = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        // The counter is still clear only in the first ACCESS cycle.
        if (cnt == '0) gnt[win_q] = 1'b1;
        if (mem_ready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        done[win_q] = 1'b1;
        err         = err_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= REQ_FETCH;
      win_q   <= REQ_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            win_q   <= win_idx;
            we_q    <= we[win_idx];
            addr_q  <= addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata[win_idx*DATA_W +: DATA_W];
            cnt     <= '0;
            err_q   <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            ptr     <= next_idx(win_q);
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            ptr     <= next_idx(win_q);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected transactions,
// a negedge monitor checks grants, memory strobes and completions.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt;
  logic [2:0]      done;
  logic            err;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;

  typedef struct {
    int            idx;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
    logic [DW-1:0] rdata;
    int            len;
  } txn_t;

  txn_t gq[$];
  txn_t dq[$];
  txn_t cur;
  txn_t dexp;
  bit   active = 1'b0;
  int   acc_len = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int            wait_cycles = 0;
  logic [DW-1:0] rd_value = '0;
  int            acc_k = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: ready after wait_cycles stalled ACCESS cycles; read data
  // is rd_value XOR the address so each access returns a distinct word.
  always @(negedge clk) begin
    if (mem_en) begin
      if (gnt != 3'b000) acc_k = 1;
      else acc_k = acc_k + 1;
      mem_ready = (acc_k > wait_cycles);
    end else begin
      mem_ready = 1'b0;
    end
    mem_rdata = rd_value ^ 16'(mem_addr);
  end

  // Monitor: pops an expectation on each grant and each completion.
  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0;
    end else begin
      if (gnt != 3'b000) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          cur = gq.pop_front();
          check("gnt_onehot", 32'(gnt), 32'd1 << cur.idx);
          active  = 1'b1;
          acc_len = 0;
        end
      end
      if (mem_en) begin
        acc_len++;
        if (!active) begin
          check("mem_en_unowned", 32'(mem_en), 32'd0);
        end else begin
          check("mem_we", 32'(mem_we), 32'(cur.we));
          check("mem_addr", 32'(mem_addr), 32'(cur.addr));
          check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        end
      end
      if (done != 3'b000) begin
        if (dq.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          dexp = dq.pop_front();
          check("done_onehot", 32'(done), 32'd1 << dexp.idx);
          check("err", 32'(err), 32'(dexp.err));
          if (!dexp.we) check("rdata", 32'(rdata), 32'(dexp.rdata));
          check("access_len", 32'(acc_len), 32'(dexp.len));
          check("mem_idle_in_resp", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
          active = 1'b0;
        end
      end
    end
  end

  task automatic expect_txn(input int idx, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input bit e,
                            input logic [DW-1:0] rd, input int len, input bit with_done);
    txn_t t;
    t.idx = idx; t.we = w; t.addr = a; t.wdata = wd;
    t.err = e; t.rdata = rd; t.len = len;
    gq.push_back(t);
    if (with_done) dq.push_back(t);
  endtask

  task automatic wait_gnt(input bit drop, output int at);
    int n = 0;
    @(negedge clk);
    while (gnt == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (gnt == 3'b000) check("gnt_wait_expired", 32'd0, 32'd1);
    at = cyc;
    if (drop) req = req & ~gnt;
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    @(negedge clk);
    while (done == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done == 3'b000) check("done_wait_expired", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic next_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t;
    int tp;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;

    // Single fetch, minimum latency
    addr[0 +: AW] = 8'h10;
    wait_cycles = 0;
    rd_value = 16'hBEFF;
    expect_txn(0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF, 1, 1'b1);
    t0 = cyc;
    req = 3'b001;
    wait_gnt(1'b1, t);
    check("fetch_gnt_latency", 32'(t - t0), 32'd1);
    wait_done(t);
    check("fetch_done_latency", 32'(t - t0), 32'd2);
    next_idle();

    // Round-robin with all three requesting continuously from reset
    reset = 1'b0;
    next_idle();
    reset = 1'b1;
    addr  = {8'h52, 8'h41, 8'h30};
    wdata = {16'h3333, 16'h2222, 16'h1111};
    we = 3'b000;
    rd_value = 16'hC000;
    expect_txn(0, 1'b0, 8'h30, 16'h1111, 1'b0, 16'hC030, 1, 1'b1);
    expect_txn(1, 1'b0, 8'h41, 16'h2222, 1'b0, 16'hC041, 1, 1'b1);
    expect_txn(2, 1'b0, 8'h52, 16'h3333, 1'b0, 16'hC052, 1, 1'b1);
    expect_txn(0, 1'b0, 8'h30, 16'h1111, 1'b0, 16'hC030, 1, 1'b1);
    req = 3'b111;
    wait_gnt(1'b0, tp);
    for (int k = 1; k < 4; k++) begin
      wait_gnt(1'b0, t);
      check("rr_grant_spacing", 32'(t - tp), 32'd3);
      tp = t;
    end
    req = 3'b000;
    wait_done(t);
    next_idle();

    // Store with four stalled cycles
    addr[AW +: AW] = 8'h20;
    wdata[DW +: DW] = 16'h1234;
    we = 3'b010;
    wait_cycles = 4;
    rd_value = 16'h0000;
    expect_txn(1, 1'b1, 8'h20, 16'h1234, 1'b0, 16'h0000, 5, 1'b1);
    req = 3'b010;
    wait_gnt(1'b1, t);
    wait_done(t);
    next_idle();
    we = 3'b000;

    // Timeout with mem_ready never asserted
    addr[2*AW +: AW] = 8'h7F;
    wait_cycles = 99;
    rd_value = 16'hFFFF;
    expect_txn(2, 1'b0, 8'h7F, 16'h3333, 1'b1, 16'h0000, TO, 1'b1);
    req = 3'b100;
    wait_gnt(1'b1, t);
    wait_done(t);
    next_idle();

    // mem_ready arrives on the last allowed cycle: no error
    addr[AW +: AW] = 8'h05;
    wait_cycles = TO - 1;
    rd_value = 16'h1200;
    expect_txn(1, 1'b0, 8'h05, 16'h1234, 1'b0, 16'h1205, TO, 1'b1);
    req = 3'b010;
    wait_gnt(1'b1, t);
    wait_done(t);
    next_idle();

    // Reset in the second ACCESS cycle abandons the transaction
    addr[0 +: AW] = 8'h44;
    wait_cycles = 99;
    expect_txn(0, 1'b0, 8'h44, 16'h1111, 1'b0, 16'h0000, 0, 1'b0);
    req = 3'b001;
    wait_gnt(1'b1, t);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_gnt", 32'(gnt), 32'd0);
    check("rst2_mem_en", 32'(mem_en), 32'd0);
    check("rst2_mem_addr", 32'(mem_addr), 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;
    addr[AW +: AW] = 8'h61;
    addr[2*AW +: AW] = 8'h62;
    wait_cycles = 0;
    rd_value = 16'h3300;
    expect_txn(1, 1'b0, 8'h61, 16'h1234, 1'b0, 16'h3361, 1, 1'b1);
    expect_txn(2, 1'b0, 8'h62, 16'h3333, 1'b0, 16'h3362, 1, 1'b1);
    req = 3'b110;
    wait_gnt(1'b1, t);
    wait_done(t);
    wait_gnt(1'b1, t);
    wait_done(t);
    next_idle();

    // Requester changes its inputs after the grant
    addr[0 +: AW] = 8'h0A;
    wait_cycles = 3;
    rd_value = 16'h0F00;
    expect_txn(0, 1'b0, 8'h0A, 16'h1111, 1'b0, 16'h0F0A, 4, 1'b1);
    req = 3'b001;
    wait_gnt(1'b1, t);
    addr[0 +: AW] = 8'hFF;
    wdata[0 +: DW] = 16'hDEAD;
    we[0] = 1'b1;
    wait_done(t);
    next_idle();
    we = 3'b000;

    repeat (3) @(posedge clk);
    #1;
    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    check("done_queue_drained", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
